// File: rtl/inst_queue_param_pkg.sv
// Shared op-class encodings and dispatch bundle for the instruction queue.
package inst_queue_param_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [2:0] {
        LUIType   = 3'd0,
        AUIPCType = 3'd1,
        JALType   = 3'd2,
        BType     = 3'd3,
        ILoadType = 3'd4,
        SType     = 3'd5,
        IType     = 3'd6,
        RType     = 3'd7
    } opera_type_e;

    typedef struct packed {
        logic rob;
        logic rs;
        logic lsb;
    } dispatch_t;

    function automatic logic is_mem_op(input opera_type_e op);
        return (op == SType) || (op == ILoadType);
    endfunction

endpackage

// File: rtl/iq_ring_buffer.sv
// Power-of-two ring of {instruction, pc} with occupancy count and flags.
import inst_queue_param_pkg::*;

module iq_ring_buffer #(
    parameter int DEPTH        = 32,
    parameter int XLEN         = 32,
    parameter int AFULL_THRESH = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [XLEN-1:0]        wr_instr,
    input  logic [XLEN-1:0]        wr_pc,
    input  logic                   rd_en,
    output logic [XLEN-1:0]        rd_instr,
    output logic [XLEN-1:0]        rd_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   is_full,
    output logic                   almost_full,
    output logic                   is_empty,
    output logic                   overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   rear;
    logic            live;
    logic            push_ok;
    logic            pop_ok;
    logic            ovf_set;

    assign live    = rdy_in && !flush;
    assign push_ok = live && wr_en && !is_full;
    assign pop_ok  = live && rd_en && !is_empty;
    assign ovf_set = live && wr_en && is_full;

    assign is_empty    = (count == '0);
    assign is_full     = (count == CW'(DEPTH));
    assign almost_full = (DEPTH - int'(count)) <= AFULL_THRESH;

    assign rd_instr = instr_mem[head];
    assign rd_pc    = pc_mem[head];

    // Storage has no reset; outputs simply show whatever head addresses.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            instr_mem[rear] <= wr_instr;
            pc_mem[rear]    <= wr_pc;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head         <= '0;
            rear         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                rear  <= '0;
                count <= '0;
            end else begin
                if (push_ok) begin
                    rear <= rear + PW'(1);
                end
                if (pop_ok) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push_ok) - CW'(pop_ok);
            end
            if (ovf_set) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_queue_param.sv
// Fetch-side instruction queue with ROB/RS/LSB dispatch routing.
// Define IQ_BYPASS_EN for zero-latency dispatch of a push into an empty queue.
import inst_queue_param_pkg::*;

module inst_queue_param #(
    parameter int DEPTH        = 32,
    parameter int XLEN         = 32,
    parameter int AFULL_THRESH = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   roll_back,
    input  logic                   instruction_ready,
    input  logic [XLEN-1:0]        instruction_in,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [2:0]             op_type_in,
    input  logic                   rob_is_full,
    input  logic                   rs_is_full,
    input  logic                   lsb_is_full,
    output logic [XLEN-1:0]        instruction_out,
    output logic [XLEN-1:0]        ins_pc_out,
    output logic                   ins_to_rob,
    output logic                   ins_to_rs,
    output logic                   ins_to_lsb,
    output logic                   is_full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err
);

    opera_type_e     op_cls;
    dispatch_t       disp;
    logic            mem_op;
    logic            have_entry;
    logic            fire;
    logic            wr_en;
    logic            is_empty;
    logic [XLEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;

    assign op_cls = opera_type_e'(op_type_in);
    assign mem_op = is_mem_op(op_cls);

`ifdef IQ_BYPASS_EN
    logic bypass;

    assign bypass = is_empty && instruction_ready && rdy_in && !roll_back;
    assign have_entry = !is_empty || bypass;
    assign instruction_out = bypass ? instruction_in : head_instr;
    assign ins_pc_out = bypass ? pc_in : head_pc;
    // A bypassed pair that dispatches never touches storage.
    assign wr_en = instruction_ready && !(bypass && fire);
`else
    assign have_entry = !is_empty;
    assign instruction_out = head_instr;
    assign ins_pc_out = head_pc;
    assign wr_en = instruction_ready;
`endif

    always_comb begin
        fire = FALSE;
        if (rdy_in && !roll_back && have_entry && !rob_is_full) begin
            fire = mem_op ? !lsb_is_full : !rs_is_full;
        end
    end

    always_comb begin
        disp     = '0;
        disp.rob = fire;
        disp.rs  = fire && !mem_op;
        disp.lsb = fire && mem_op;
    end

    assign ins_to_rob = disp.rob;
    assign ins_to_rs  = disp.rs;
    assign ins_to_lsb = disp.lsb;

    iq_ring_buffer #(
        .DEPTH        (DEPTH),
        .XLEN         (XLEN),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ring (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (roll_back),
        .wr_en        (wr_en),
        .wr_instr     (instruction_in),
        .wr_pc        (pc_in),
        .rd_en        (fire),
        .rd_instr     (head_instr),
        .rd_pc        (head_pc),
        .count        (count),
        .is_full      (is_full),
        .almost_full  (almost_full),
        .is_empty     (is_empty),
        .overflow_err (overflow_err)
    );

endmodule
